// File: rtl/led_bar_writer.sv
// Bar-graph writer: maps a reading onto TOTAL lit/dark cells and writes each matrix cell once, in address order.
// Latency: first write the cycle after load (or after frame_tick when synced), done_tick one cycle after the last write; load is ignored while busy.
module led_bar_writer #(
  parameter int LEDS_N   = 4,
  parameter int LEDS_M   = 2,
  parameter int N_BITS   = 2,
  parameter int M_BITS   = 2,
  parameter int VAL_BITS = 12,
  localparam int TOTAL     = LEDS_N * LEDS_M,
  localparam int ADDR_BITS = N_BITS + M_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VAL_BITS-1:0]  value,
  input  logic [VAL_BITS-1:0]  value_max,
  input  logic                 load,
  input  logic                 sync,
  input  logic                 frame_tick,
  output logic                 busy,
  output logic                 sel,
  output logic [ADDR_BITS-1:0] sel_addr,
  output logic                 en,
  output logic                 done_tick
);

  localparam int ACC_W = VAL_BITS + ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [VAL_BITS-1:0]  r_max, w_max_nxt;
  logic [ACC_W-1:0]     r_target, w_target_nxt;
  logic [ACC_W-1:0]     r_acc, w_acc_nxt;
  logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
  logic                 r_sel, w_sel_nxt;
  logic                 r_en, w_en_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;

  logic [ACC_W-1:0]     w_target_in;
  logic [ACC_W-1:0]     w_acc_inc;

  // r_acc always holds r_addr*r_max, so cell a is lit iff a*max < value*TOTAL
  assign w_target_in = {{ADDR_BITS{1'b0}}, value} * ACC_W'(TOTAL);
  assign w_acc_inc   = r_acc + {{ADDR_BITS{1'b0}}, r_max};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_max_nxt    = r_max;
    w_target_nxt = r_target;
    w_acc_nxt    = r_acc;
    w_addr_nxt   = r_addr;
    w_sel_nxt    = 1'b0;
    w_en_nxt     = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_max_nxt    = value_max;
          w_target_nxt = w_target_in;
          w_acc_nxt    = '0;
          w_addr_nxt   = '0;
          w_busy_nxt   = 1'b1;
          if (sync) begin
            w_state_nxt = WAIT_FRAME;
          end else begin
            w_state_nxt = WRITE;
            w_sel_nxt   = 1'b1;
            w_en_nxt    = (value_max != '0) && (w_target_in != '0);
          end
        end
      end
      WAIT_FRAME: begin
        if (frame_tick) begin
          w_state_nxt = WRITE;
          w_sel_nxt   = 1'b1;
          w_en_nxt    = (r_max != '0) && (r_target != '0);
        end
      end
      WRITE: begin
        if (r_addr == LAST) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_addr_nxt  = '0;
          w_acc_nxt   = '0;
        end else begin
          w_sel_nxt  = 1'b1;
          w_addr_nxt = r_addr + ADDR_BITS'(1);
          w_acc_nxt  = w_acc_inc;
          w_en_nxt   = (r_max != '0) && (w_acc_inc < r_target);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max    <= '0;
      r_target <= '0;
      r_acc    <= '0;
      r_addr   <= '0;
      r_sel    <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_max    <= w_max_nxt;
      r_target <= w_target_nxt;
      r_acc    <= w_acc_nxt;
      r_addr   <= w_addr_nxt;
      r_sel    <= w_sel_nxt;
      r_en     <= w_en_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign busy      = r_busy;
  assign sel       = r_sel;
  assign sel_addr  = r_addr;
  assign en        = r_en;
  assign done_tick = r_done;

endmodule

// File: tb/tb_led_bar_writer.sv
// Directed bench for led_bar_writer: expected lit masks are hand-computed from a*value_max < value*8.
module tb_led_bar_writer;

  logic        clk;
  logic        reset;
  logic [11:0] value;
  logic [11:0] value_max;
  logic        load;
  logic        sync;
  logic        frame_tick;
  logic        busy;
  logic        sel;
  logic [3:0]  sel_addr;
  logic        en;
  logic        done_tick;

  int n_vec = 0;
  int n_err = 0;

  led_bar_writer dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .value_max  (value_max),
    .load       (load),
    .sync       (sync),
    .frame_tick (frame_tick),
    .busy       (busy),
    .sel        (sel),
    .sel_addr   (sel_addr),
    .en         (en),
    .done_tick  (done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that starts the writes; checks 8 writes, done_tick and the idle cycle.
  task automatic check_writes(input string tag, input logic [7:0] mask, input bit mid_load);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_sel"}, 32'(sel), 32'd1);
      chk({tag, "_addr"}, 32'(sel_addr), 32'(i));
      chk({tag, "_en"}, 32'(en), 32'(mask[i]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done_tick), 32'd0);
      if (mid_load && i == 2) begin
        load  = 1'b1;
        value = 12'd100;
      end
      if (mid_load && i == 6) load = 1'b0;
      step();
    end
    chk({tag, "_done"}, 32'(done_tick), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_sel"}, 32'(sel), 32'd0);
    step();
    chk({tag, "_idle_done"}, 32'(done_tick), 32'd0);
    chk({tag, "_idle_sel"}, 32'(sel), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic update(input string tag, input logic [11:0] v, input logic [11:0] m,
                        input logic [7:0] mask, input bit mid_load);
    value     = v;
    value_max = m;
    sync      = 1'b0;
    load      = 1'b1;
    step();
    load = 1'b0;
    check_writes(tag, mask, mid_load);
  endtask

  initial begin
    reset      = 1'b0;
    value      = '0;
    value_max  = '0;
    load       = 1'b0;
    sync       = 1'b0;
    frame_tick = 1'b0;
    step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_addr", 32'(sel_addr), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_tick), 32'd0);
    reset = 1'b1;
    step();

    // Basic update and lit-count patterns
    update("v50", 12'd50, 12'd100, 8'h0F, 1'b0);
    update("v12", 12'd12, 12'd100, 8'h01, 1'b0);
    update("v13", 12'd13, 12'd100, 8'h03, 1'b0);
    update("v0", 12'd0, 12'd100, 8'h00, 1'b0);
    update("v100", 12'd100, 12'd100, 8'hFF, 1'b0);
    update("v150", 12'd150, 12'd100, 8'hFF, 1'b0);
    update("max0", 12'd50, 12'd0, 8'h00, 1'b0);
    update("v4095", 12'd4095, 12'd4095, 8'hFF, 1'b0);

    // Synced: frame_tick alongside load is not honoured, then 20 idle cycles
    value      = 12'd50;
    value_max  = 12'd100;
    sync       = 1'b1;
    load       = 1'b1;
    frame_tick = 1'b1;
    step();
    load       = 1'b0;
    sync       = 1'b0;
    frame_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("wait_sel", 32'(sel), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      step();
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check_writes("sync", 8'h0F, 1'b0);

    // frame_tick while idle must not start anything
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("idle_ft_sel", 32'(sel), 32'd0);
    chk("idle_ft_busy", 32'(busy), 32'd0);

    // load while busy plus value change mid-write: no effect, no second update
    update("midload", 12'd50, 12'd100, 8'h0F, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("nosecond_sel", 32'(sel), 32'd0);
      chk("nosecond_busy", 32'(busy), 32'd0);
      step();
    end

    // Reset during the 4th write
    value     = 12'd50;
    value_max = 12'd100;
    load      = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_addr", 32'(sel_addr), 32'd3);
    chk("pre_rst_sel", 32'(sel), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done_tick), 32'd0);
    chk("midrst_addr", 32'(sel_addr), 32'd0);
    #1;
    reset = 1'b1;
    step();
    update("postrst", 12'd100, 12'd100, 8'hFF, 1'b0);

    // Back-to-back with load held high: 10-cycle period
    value     = 12'd13;
    value_max = 12'd100;
    load      = 1'b1;
    step();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        chk("b2b_sel", 32'(sel), 32'd1);
        chk("b2b_addr", 32'(sel_addr), 32'(i));
        chk("b2b_en", 32'(en), (i < 2) ? 32'd1 : 32'd0);
        step();
      end
      chk("b2b_done", 32'(done_tick), 32'd1);
      chk("b2b_done_sel", 32'(sel), 32'd0);
      step();
      chk("b2b_gap_sel", 32'(sel), 32'd0);
      chk("b2b_gap_done", 32'(done_tick), 32'd0);
      chk("b2b_gap_busy", 32'(busy), 32'd0);
      if (r == 2) load = 1'b0;
      step();
    end
    chk("b2b_end_sel", 32'(sel), 32'd0);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_bar_writer.md
Name: led_bar_writer

Overview:
- Producer side of the LED matrix register-file write interface.
- Converts a scalar reading (e.g. boost level) into a bar-graph lit count and writes every matrix cell once, one address per cycle, over the sel/sel_addr/en port.
- Can optionally hold off until the matrix signals end-of-scan, so the bar updates between frames.
- Sits between the gauge datapath and the matrix driver: its done_tick feeds the matrix frame_tick input, and its sel/sel_addr/en outputs drive the matrix write port.

Parameters:
- LEDS_N, 4, matrix input-enable count
- LEDS_M, 2, matrix output-enable count
- N_BITS, 2, N index bits
- M_BITS, 2, M index bits
- VAL_BITS, 12, reading/full-scale precision
- Derived: TOTAL = LEDS_N*LEDS_M; ADDR_BITS = N_BITS+M_BITS.

Ports:
- clk  in  1  global clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- value  in  VAL_BITS  reading to display
- value_max  in  VAL_BITS  full-scale reading
- load  in  1  request an update; sampled only in IDLE
- sync  in  1  1 = wait for frame_tick before writing; sampled with load
- frame_tick  in  1  end-of-scan pulse from the matrix
- busy  out  1  high from the cycle after an accepted load through done_tick
- sel  out  1  write strobe, one cell per cycle
- sel_addr  out  ADDR_BITS  cell address
- en  out  1  cell enable value
- done_tick  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (reset=0, async): state IDLE. sel, sel_addr, en, busy and done_tick all 0; internal counters 0. Cells already written are not retracted.
- All outputs are registered.
- Capture on load in IDLE at edge k:
  - val_r <= value, max_r <= value_max, sync_r <= sync.
  - target <= value*TOTAL, width VAL_BITS+ADDR_BITS, no truncation.
  - acc <= 0, a <= 0, busy <= 1.
  - Next state: WAIT_FRAME if sync=1, else WRITE.
- WAIT_FRAME: hold until frame_tick=1, then go to WRITE. sel stays 0 while waiting.
- WRITE, one cell per cycle:
  - sel=1, sel_addr=a, en = (max_r!=0) && (acc < target).
  - Then a <= a+1, acc <= acc+max_r.
  - After a = TOTAL-1, go to DONE.
  - acc width is VAL_BITS+ADDR_BITS, so it cannot overflow.
- Lit-cell rule: cell a is lit iff a*value_max < value*TOTAL. Consequences:
  - value=0 → all cells dark.
  - value >= value_max → all cells lit.
  - value_max=0 → all cells dark.
- DONE: done_tick=1 and busy=0 for one cycle, sel=0, then IDLE.
- Latency:
  - sync=0: first write in cycle k+1, last write in k+TOTAL, done_tick in k+TOTAL+1.
  - sync=1: with frame_tick seen at edge j, first write in j+1, done_tick in j+TOTAL+1.
- Boundaries:
  - load while busy: ignored, no queueing.
  - frame_tick outside WAIT_FRAME: ignored.
  - value/value_max changing after capture: no effect on the current update.
  - load and frame_tick in the same cycle with sync=1: frame_tick is not yet honoured; the block waits for the next frame_tick.
  - load in the same cycle as done_tick: not accepted; it is accepted in the following IDLE cycle.
  - reset asserted mid-WRITE: outputs return to 0 immediately; a new load afterwards performs a full TOTAL-cell write from address 0.
  - sel_addr always walks 0..TOTAL-1 in order; no address >= TOTAL is ever issued.

Test Plan:
1. Defaults, value_max=100, value=50, sync=0, load at edge k → sel high for cycles k+1..k+8, en=1,1,1,1,0,0,0,0 at addresses 0..7, done_tick in k+9, busy low after.
2. value_max=100; value=12 → only address 0 lit; value=13 → addresses 0,1 lit; value=0 → none lit; value=100 and value=150 → all 8 lit; value_max=0, value=50 → none lit.
3. sync=1, load, frame_tick held 0 for 20 cycles → sel stays 0, busy=1; pulse frame_tick at edge j → first write in j+1, done_tick in j+9.
4. load asserted while busy, and value changed mid-write → write count stays exactly 8 and en pattern matches the originally captured value; no second update occurs.
5. reset pulled low during the 4th write → sel, busy, done_tick 0 in the same cycle; after release, load value=100 → 8 writes from address 0, all en=1.
6. Back-to-back operation: load held high continuously, sync=0 → writes of 8 cycles, an idle gap, and done_tick repeating every 10 cycles; no overlap and no skipped address.
